// File: rtl/div_unit_if.sv
// Handshake and operand/result bus of the sequential divider.
// The control side (master) drives the start request and operands.
// The divider (slave) returns the flag-packed quotient, remainder, busy and done.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             div_en;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH+3:0] out;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             done;

  modport master (
    output div_en, in1, in2,
    input  out, rem, busy, done
  );

  modport slave (
    input  div_en, in1, in2,
    output out, rem, busy, done
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock.
// Result packing matches the multiplier: {N, Z, C, V, quotient}, so the ALU
// mux can select either unit without reformatting.
// Build option: define DIV_SIGNED_EN for two's-complement signed operands;
// otherwise the operands are unsigned and no sign logic is built.
// Sequence: IDLE -(start)-> RUN (WIDTH iterations) -> FIX -> IDLE.
// A zero divisor skips RUN/FIX and returns {q=0, rem=dividend, V=1} at once.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      clr,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] quo_reg;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_reg;    // divisor magnitude
  logic [WIDTH-1:0] prem_reg;   // partial remainder
  logic             ovf_reg;    // MIN / -1 detected at start
  logic [WIDTH+3:0] out_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] prem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             min_ovf;

  // Pack a quotient with its flags; carry is never produced by a divide.
  function automatic logic [WIDTH+3:0] pack_result(input logic [WIDTH-1:0] q,
                                                   input logic             v);
    return {q[WIDTH-1], (q == '0), 1'b0, v, q};
  endfunction

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    shifted = {prem_reg, quo_reg[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_reg};
    if (!trial[WIDTH]) begin
      prem_next = trial[WIDTH-1:0];
      quo_next  = {quo_reg[WIDTH-2:0], 1'b1};
    end else begin
      prem_next = shifted[WIDTH-1:0];
      quo_next  = {quo_reg[WIDTH-2:0], 1'b0};
    end
  end

`ifdef DIV_SIGNED_EN
  logic neg_q_reg;  // operand signs differ: negate quotient
  logic neg_r_reg;  // dividend negative: remainder follows its sign

  // Magnitudes at the input, sign correction at the output, MIN / -1 detect.
  always_comb begin
    a_mag   = bus.in1[WIDTH-1] ? -bus.in1 : bus.in1;
    b_mag   = bus.in2[WIDTH-1] ? -bus.in2 : bus.in2;
    q_fix   = neg_q_reg ? -quo_reg : quo_reg;
    r_fix   = neg_r_reg ? -prem_reg : prem_reg;
    min_ovf = (bus.in1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.in2);
  end

  // Sign bits are captured alongside the operands on an accepted start.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (state_reg == IDLE && bus.div_en && bus.in2 != '0) begin
      neg_q_reg <= bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1];
      neg_r_reg <= bus.in1[WIDTH-1];
    end
  end
`else
  // Unsigned: operands and results pass straight through.
  always_comb begin
    a_mag   = bus.in1;
    b_mag   = bus.in2;
    q_fix   = quo_reg;
    r_fix   = prem_reg;
    min_ovf = 1'b0;
  end
`endif

  // Control FSM with registered result, busy and done.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= IDLE;
      count_reg <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      prem_reg  <= '0;
      ovf_reg   <= 1'b0;
      out_reg   <= '0;
      rem_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.div_en) begin
            if (bus.in2 != '0) begin
              quo_reg   <= a_mag;
              dvs_reg   <= b_mag;
              prem_reg  <= '0;
              count_reg <= '0;
              ovf_reg   <= min_ovf;
              busy_reg  <= 1'b1;
              state_reg <= RUN;
            end else begin
              // Divide-by-zero: answer immediately, never go busy.
              out_reg  <= pack_result('0, 1'b1);
              rem_reg  <= bus.in1;
              done_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          prem_reg  <= prem_next;
          quo_reg   <= quo_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(WIDTH - 1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          out_reg   <= pack_result(q_fix, ovf_reg);
          rem_reg   <= r_fix;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = out_reg;
  assign bus.rem  = rem_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle sequential divider: the inverse operation to the combinational multiplier in the ALU datapath.
- Computes the 32-bit quotient and remainder of in1 / in2 using a radix-2 restoring algorithm, one quotient bit per clock.
- The 36-bit result uses the same flag packing as the multiplier: {N, Z, C, V, quotient}. The ALU mux selects either unit with no reformatting.
- A start/busy/done handshake lets the control unit stall the datapath for the duration of a divide.

Parameters:
- WIDTH, 32, operand, quotient and remainder width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-low reset.
- div_en  input  1  start request; sampled on a rising edge while idle.
- in1  input  WIDTH  dividend; captured on an accepted start.
- in2  input  WIDTH  divisor; captured on an accepted start.
- out  output  WIDTH+4  {isNegative, isZero, hasCarry, hasOverflow, quotient}.
- rem  output  WIDTH  remainder.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when out/rem update.

Behaviour:
- Reset: clr low asynchronously forces the following, regardless of state.
  - state = IDLE
  - out = 0, rem = 0, busy = 0, done = 0
  - all internal registers = 0
- States:
  - IDLE -> RUN when div_en = 1 and in2 != 0.
  - IDLE -> IDLE with a registered result when div_en = 1 and in2 == 0 (divide-by-zero).
  - RUN -> RUN for WIDTH iterations.
  - RUN -> FIX after the last iteration.
  - FIX -> IDLE.
- Start (edge 0):
  - Latch the magnitudes of in1 and in2, plus the sign bits.
  - Clear the partial remainder and set count = 0.
  - busy = 1.
- RUN, edges 1..WIDTH, once per edge:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
- FIX (edge WIDTH+1):
  - Apply sign correction: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend (truncation toward zero).
  - Register out and rem, pulse done = 1 for exactly one cycle, busy = 0, return to IDLE.
- Latency:
  - Normal operation: done is high in the cycle after edge WIDTH+1 (33 cycles for WIDTH = 32). busy is high from edge 0 through edge WIDTH+1.
  - Divide-by-zero: at edge 0 go directly to the result. quotient = 0, rem = dividend, done = 1 after edge 0, busy never asserts.
- Flags:
  - isNegative = quotient[WIDTH-1].
  - isZero = (quotient == 0).
  - hasCarry = 0 always.
  - hasOverflow = 1 on divide-by-zero, or on signed MIN / -1; otherwise 0.
- MIN / -1 needs no special datapath. The algorithm yields quotient 0x80000000 and rem 0; only V is forced to 1.
- div_en while busy: ignored. Operands are not re-captured.
- div_en in the cycle done is high: accepted, because state is already IDLE. A new operation starts and done drops on that edge.
- out/rem hold their last result until the next done. They never show intermediate values.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and outputs return to 0.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: operands are two's-complement signed. Magnitude conversion and sign correction as above; MIN / -1 sets V.
- Undefined: operands are unsigned. No magnitude or sign-correction logic is built; the FIX state still exists, so latency is identical. V = 1 only on divide-by-zero.

Test Plan:
- in1 = 100, in2 = 7, div_en pulse -> after 33 cycles: done = 1, out[31:0] = 14, rem = 2, flags NZCV = 0000; busy high for exactly 33 cycles.
- (DIV_SIGNED_EN) in1 = 0xFFFFFF9C (-100), in2 = 7 -> out[31:0] = 0xFFFFFFF2, rem = 0xFFFFFFFE, N = 1, Z = 0, V = 0.
- in1 = 5, in2 = 0 -> done on the next cycle, busy never high, out[31:0] = 0, rem = 5, Z = 1, V = 1, N = 0, C = 0.
- in1 = 0x80000000, in2 = 0xFFFFFFFF:
  - signed build -> quotient 0x80000000, rem 0, N = 1, V = 1.
  - unsigned build -> quotient 0, rem 0x80000000, Z = 1, V = 0.
- Start 100/7, pulse div_en again at cycle 5 with in1 = 9, in2 = 3 -> ignored; result is still 14 rem 2. Then a back-to-back start in the done cycle with 3/10 -> quotient 0, rem 3, Z = 1, 33 cycles later.
- Start 100/7, drive clr low at cycle 10 -> busy = 0, out = 0, rem = 0 immediately, no done. Release clr, start 9/3 -> quotient 3, rem 0 after 33 cycles.
